// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side channels around the shared port.
// master is the arbiter's view; slave is the view of the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_data;

  logic              dm_req_valid;
  logic              dm_req_ready;
  logic [ADDR_W-1:0] dm_req_addr;
  logic              dm_req_write;
  logic [DATA_W-1:0] dm_req_wdata;
  logic [MASK_W-1:0] dm_req_wmask;
  logic              dm_resp_valid;
  logic [DATA_W-1:0] dm_resp_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_write;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport master (
    input  if_req_valid, if_req_addr,
    input  dm_req_valid, dm_req_addr, dm_req_write, dm_req_wdata, dm_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output if_req_ready, if_resp_valid, if_resp_data,
    output dm_req_ready, dm_resp_valid, dm_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wmask
  );

  modport slave (
    output if_req_valid, if_req_addr,
    output dm_req_valid, dm_req_addr, dm_req_write, dm_req_wdata, dm_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  dm_req_ready, dm_resp_valid, dm_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Load/store wins contention until MAX_STREAK back-to-back contested wins, then fetch goes.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int STRK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STRK_W-1:0] STREAK_LIM = STRK_W'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  mem_req_t          req_q, req_d;
  logic [STRK_W-1:0] streak_q, streak_d;
  logic              streak_full, grant_if, grant_dm, resp_fire;
  logic              if_resp_valid_q, dm_resp_valid_q;
  logic [DATA_W-1:0] if_resp_data_q, dm_resp_data_q;

  // Fetch wins only when alone or when load/store has used up its streak.
  assign streak_full = (streak_q == STREAK_LIM);
  assign grant_if    = bus.if_req_valid && (!bus.dm_req_valid || streak_full);
  assign grant_dm    = bus.dm_req_valid && !grant_if;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    req_d            = req_q;
    streak_d         = streak_q;
    resp_fire        = 1'b0;
    bus.if_req_ready = 1'b0;
    bus.dm_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          bus.if_req_ready = 1'b1;
          owner_d          = OWN_IF;
          req_d            = '{addr: bus.if_req_addr, write: 1'b0, wdata: '0, wmask: '0};
          streak_d         = '0;
          state_d          = REQ;
        end else if (grant_dm) begin
          bus.dm_req_ready = 1'b1;
          owner_d          = OWN_DM;
          req_d            = '{addr: bus.dm_req_addr, write: bus.dm_req_write,
                               wdata: bus.dm_req_wdata, wmask: bus.dm_req_wmask};
          if (bus.if_req_valid && !streak_full) streak_d = streak_q + STRK_W'(1);
          state_d          = REQ;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          resp_fire = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      req_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
      streak_q <= streak_d;
    end
  end

  // Responses are registered so the requester sees a clean one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_resp_valid_q <= 1'b0;
      dm_resp_valid_q <= 1'b0;
      if_resp_data_q  <= '0;
      dm_resp_data_q  <= '0;
    end else begin
      if_resp_valid_q <= resp_fire && (owner_q == OWN_IF);
      dm_resp_valid_q <= resp_fire && (owner_q == OWN_DM);
      if (resp_fire && owner_q == OWN_IF) if_resp_data_q <= bus.mem_resp_data;
      if (resp_fire && owner_q == OWN_DM) dm_resp_data_q <= req_q.write ? '0 : bus.mem_resp_data;
    end
  end

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = req_q.addr;
  assign bus.mem_req_write = req_q.write;
  assign bus.mem_req_wdata = req_q.wdata;
  assign bus.mem_req_wmask = req_q.wmask;
  assign bus.if_resp_valid = if_resp_valid_q;
  assign bus.if_resp_data  = if_resp_data_q;
  assign bus.dm_resp_valid = dm_resp_valid_q;
  assign bus.dm_resp_data  = dm_resp_data_q;

  a_ready_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.if_req_ready && bus.dm_req_ready));
  a_resp_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.if_resp_valid && bus.dm_resp_valid));
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between instruction fetch and load/store. Each requester gets a valid/ready request channel and a one-cycle response pulse. Only one transaction is outstanding at a time. Load/store normally has priority, and a streak counter stops fetch from being starved indefinitely. Sits between the fetch stage and the load/store unit, which is driven by the decoder's memory-request and request-type outputs, on one side, and the memory interface on the other.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_STREAK, 4, consecutive contested data grants before fetch is forced to win; legal range ≥1

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_resp_valid  out  1  one-cycle pulse, fetch data valid
- if_resp_data  out  DATA_W  fetched instruction
- dm_req_valid  in  1  load/store request
- dm_req_ready  out  1  load/store request accepted this cycle
- dm_req_addr  in  ADDR_W  data address
- dm_req_write  in  1  1 = store, 0 = load
- dm_req_wdata  in  DATA_W  store data
- dm_req_wmask  in  DATA_W/8  byte enables for stores
- dm_resp_valid  out  1  one-cycle pulse, load data valid or store complete
- dm_resp_data  out  DATA_W  load data; 0 for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr / mem_req_write / mem_req_wdata / mem_req_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  latched request payload
- mem_resp_valid  in  1  memory response; one per accepted request, reads and writes alike
- mem_resp_data  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Arbitration is combinational.
  - If only one requester is valid, it is granted.
  - If both are valid, data is granted unless streak == MAX_STREAK, in which case fetch is granted.
  - The granted requester's ready is asserted this cycle and its payload is latched. The owner (IF/DM) is recorded and the FSM moves to REQ.
  - Fetch payload is latched as write=0, wdata=0, wmask=0.
- REQ:
  - mem_req_valid=1 and the payload is held stable.
  - On mem_req_valid && mem_req_ready, the FSM moves to WAIT.
- WAIT:
  - On mem_resp_valid, the owner's resp_valid is registered high for exactly one cycle.
  - resp_data is mem_resp_data for reads and 0 for stores.
  - The FSM returns to IDLE.
- mem_resp_valid in IDLE or REQ is ignored.
- Both readys are 0 outside IDLE. Requesters hold valid and payload until they see ready.
- Streak counter (saturating, range 0..MAX_STREAK):
  - Increments on a data grant while if_req_valid=1.
  - Clears on any fetch grant.
  - Unchanged on an uncontested data grant.
- Reset: FSM in IDLE; streak=0; owner=IF; all outputs 0 except the combinational readys.
  - Reset mid-transaction abandons it. No response pulse is emitted afterwards.

## Timing
- Request accepted (ready && valid) at cycle T → mem_req_valid=1 at T+1.
- mem_req_ready=1 at T+1 → WAIT from T+2. Each cycle mem_req_ready is low adds one cycle in REQ.
- mem_resp_valid at cycle W → owner resp_valid=1 at W+1, FSM in IDLE at W+1.
- A new request can be accepted at W+1, so the next mem_req_valid appears at W+2.
- Minimum occupancy with zero-wait memory (ready at T+1, response at T+2): 3 cycles per transaction.
- if_resp_valid and dm_resp_valid are never high in the same cycle. Both readys are never high in the same cycle.

## Test plan
- Lone fetch:
  - Stimulus: if_req_valid=1, addr 0x100; mem_req_ready=1 at T+1; mem_resp_valid at T+2 with data 0x00500093.
  - Required: if_req_ready at T; mem_req_valid only at T+1 with addr 0x100 and write=0; if_resp_valid pulse at T+3 with data 0x00500093.
- Store:
  - Stimulus: dm store, addr 0x200, wdata 0xDEADBEEF, wmask 0xF; mem_req_ready held low 3 cycles.
  - Required: mem_req_valid held 4 cycles with payload stable; dm_resp_valid pulse with data 0 one cycle after mem_resp_valid.
- Contention, MAX_STREAK=4:
  - Stimulus: both requesters continuously valid.
  - Required: grant order DM, DM, DM, DM, IF, DM, DM, DM, DM, IF; streak returns to 0 after each IF grant.
- Spurious response:
  - Stimulus: mem_resp_valid pulsed while in IDLE and while in REQ.
  - Required: no resp_valid on either port; state unaffected.
- Reset in WAIT:
  - Stimulus: assert rst asynchronously between clock edges while in WAIT.
  - Required: mem_req_valid=0 immediately; no resp pulse on either port after reset release; the next request completes normally.
- Back-to-back loads:
  - Stimulus: 3 back-to-back loads with zero-wait memory.
  - Required: dm_req_ready every 3 cycles; responses in order with the correct data.
